// File: rtl/mem_arbiter.sv
// Two-port fixed-priority arbiter (data over fetch) sharing one memory via grant/complete cycles.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {StIdle, StWait} state_t;

    state_t r_state;
    logic   r_is_fetch;
    logic   r_is_store;
    logic   w_starved;
    logic   w_if_win;
    logic   w_accept;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Counts data grants won while fetch was also waiting; any fetch grant clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (w_accept) begin
            if (w_if_win) begin
                r_starve_cnt <= '0;
            end else if (i_if_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_starve_max;

    assign w_starved           = 1'b0;
    assign w_unused_starve_max = ^STARVE_MAX;
`endif

    assign w_accept = (r_state == StIdle) && (i_if_req || i_d_req);
    assign w_if_win = i_if_req && (!i_d_req || w_starved);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_is_fetch  <= 1'b0;
            r_is_store  <= 1'b0;
            o_if_gnt    <= 1'b0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_d_gnt     <= 1'b0;
            o_d_valid   <= 1'b0;
            o_d_rdata   <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    o_if_valid <= 1'b0;
                    o_d_valid  <= 1'b0;
                    if (w_accept) begin
                        r_state <= StWait;
                        if (w_if_win) begin
                            r_is_fetch  <= 1'b1;
                            r_is_store  <= 1'b0;
                            o_if_gnt    <= 1'b1;
                            o_mem_addr  <= i_if_addr;
                            o_mem_read  <= 1'b1;
                            o_mem_write <= 1'b0;
                        end else begin
                            r_is_fetch  <= 1'b0;
                            r_is_store  <= i_d_we;
                            o_d_gnt     <= 1'b1;
                            o_mem_addr  <= i_d_addr;
                            o_mem_wdata <= i_d_wdata;
                            o_mem_read  <= !i_d_we;
                            o_mem_write <= i_d_we;
                        end
                    end
                end
                StWait: begin
                    r_state     <= StIdle;
                    o_if_gnt    <= 1'b0;
                    o_d_gnt     <= 1'b0;
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                    if (r_is_fetch) begin
                        o_if_rdata <= i_mem_rdata;
                        o_if_valid <= 1'b1;
                    end else begin
                        // Stores leave the last load result visible.
                        if (!r_is_store) begin
                            o_d_rdata <= i_mem_rdata;
                        end
                        o_d_valid <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
